// File: rtl/bram_fifo_pkg.sv
// Shared definitions for the block-RAM FIFO controller: arbiter priority encoding,
// output buffer depth and the level-counter width helper.
package bram_fifo_pkg;

    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_e;

    localparam int BUF_DEPTH = 2;

    // Level must hold DEPTH RAM words plus every word in the buffer and in flight.
    function automatic int lvl_width(input int aw);
        return $clog2((1 << aw) + BUF_DEPTH) + 1;
    endfunction

endpackage

// File: rtl/bram_fifo_outbuf.sv
// Two-entry output buffer fed by block-RAM read data; head is presented straight from
// a register so the consumer sees no combinational path from the RAM.
module bram_fifo_outbuf
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_dat,
    input  logic                  i_pop,
    output logic [1:0]            o_occ,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_head_valid
);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic                  r_wr_idx;
    logic                  r_rd_idx;
    logic [1:0]            r_occ;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_idx] <= i_push_dat;
                r_wr_idx        <= ~r_wr_idx;
            end
            if (i_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_occ        = r_occ;
    assign o_head       = r_mem[r_rd_idx];
    assign o_head_valid = (r_occ != 2'd0);

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Streaming FIFO controller owning the single port of a 1-cycle-latency block RAM.
// Optional high-water-mark tracking is built when BRAM_FIFO_HWM_EN is defined.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  ADDR_WIDTH = 8,
    localparam int LVL_W      = lvl_width(ADDR_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [LVL_W-1:0]      o_level,
`ifdef BRAM_FIFO_HWM_EN
    output logic [LVL_W-1:0]      o_hwm,
    input  logic                  i_hwm_clr,
`endif
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_din,
    input  logic [DATA_WIDTH-1:0] i_ram_dout
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [ADDR_WIDTH:0]   r_ram_cnt;
    logic                  r_pending;
    prio_e                 r_prio;

    logic       w_full;
    logic       w_ram_empty;
    logic       w_pop;
    logic       w_rd_want;
    logic       w_rd_first;
    logic       w_wr_grant;
    logic       w_rd_grant;
    logic       w_contend;
    logic [1:0] w_occ;

    assign w_full      = (r_ram_cnt == DEPTH);
    assign w_ram_empty = (r_ram_cnt == '0);
    assign w_pop       = o_rd_valid && i_rd_ready;
    // A read may only issue if its word is guaranteed a buffer slot when it lands.
    assign w_rd_want   = !w_ram_empty &&
                         (({1'b0, w_occ} + {2'b0, r_pending}) < (3'd2 + {2'b0, w_pop}));
    assign w_rd_first  = w_rd_want && (r_prio == PRIO_RD);
    assign w_wr_grant  = !i_rst && !w_rd_first && i_wr_valid && !w_full;
    assign w_rd_grant  = !i_rst && w_rd_want && !w_wr_grant;
    assign w_contend   = w_rd_want && i_wr_valid && !w_full;

    assign o_wr_ready  = !i_rst && !w_full && !w_rd_first;
    assign o_ram_we    = w_wr_grant;
    assign o_ram_din   = w_wr_grant ? i_wr_data : '0;
    assign o_ram_addr  = i_rst      ? '0       :
                         w_wr_grant ? r_wr_ptr :
                         w_rd_grant ? r_rd_ptr : r_ram_addr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_addr <= '0;
            r_ram_cnt  <= '0;
            r_pending  <= 1'b0;
            r_prio     <= PRIO_WR;
        end else begin
            if (w_wr_grant) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_grant) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_ram_cnt  <= r_ram_cnt + {{ADDR_WIDTH{1'b0}}, w_wr_grant}
                                    - {{ADDR_WIDTH{1'b0}}, w_rd_grant};
            r_pending  <= w_rd_grant;
            r_ram_addr <= o_ram_addr;
            if (w_contend) begin
                r_prio <= (r_prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
            end
        end
    end

    bram_fifo_outbuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_outbuf (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (r_pending),
        .i_push_dat   (i_ram_dout),
        .i_pop        (w_pop),
        .o_occ        (w_occ),
        .o_head       (o_rd_data),
        .o_head_valid (o_rd_valid)
    );

    assign o_level = LVL_W'(r_ram_cnt) + LVL_W'(r_pending) + LVL_W'(w_occ);

`ifdef BRAM_FIFO_HWM_EN
    logic [LVL_W-1:0] r_hwm;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hwm <= '0;
        end else if (i_hwm_clr || (o_level > r_hwm)) begin
            r_hwm <= o_level;
        end
    end

    assign o_hwm = r_hwm;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl with an inline 1-cycle-latency block RAM behind it
// and a queue scoreboard checking every popped word.
module tb_bram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic [9:0] level;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
`ifdef BRAM_FIFO_HWM_EN
    logic [9:0] hwm;
    logic       hwm_clr;
`endif

    logic [7:0] mem [256];
    logic [7:0] exp_q [$];
    int tests = 0;
    int fails = 0;
    int n_pop = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    bram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_valid (wr_valid),
        .o_wr_ready (wr_ready),
        .i_wr_data  (wr_data),
        .o_rd_valid (rd_valid),
        .i_rd_ready (rd_ready),
        .o_rd_data  (rd_data),
        .o_level    (level),
`ifdef BRAM_FIFO_HWM_EN
        .o_hwm      (hwm),
        .i_hwm_clr  (hwm_clr),
`endif
        .o_ram_we   (ram_we),
        .o_ram_addr (ram_addr),
        .o_ram_din  (ram_din),
        .i_ram_dout (ram_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered one time unit after a rising edge; returns one time unit after the next.
    task automatic cyc(output logic wacc, output logic we);
        logic       racc;
        logic [7:0] rdat, wdat, e;
        #1;
        wacc = wr_valid && wr_ready;
        racc = rd_valid && rd_ready;
        rdat = rd_data;
        wdat = wr_data;
        we   = ram_we;
        @(posedge clk);
        #1;
        if (wacc) exp_q.push_back(wdat);
        if (racc) begin
            n_pop++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pop_data", 32'(rdat), 32'(e));
            end else begin
                chk("pop_unexpected", 32'(racc), 32'(0));
            end
        end
    endtask

    task automatic idle(input int n);
        logic a, we;
        repeat (n) cyc(a, we);
    endtask

    task automatic write_word(input logic [7:0] d);
        logic a, we;
        a        = 1'b0;
        wr_valid = 1'b1;
        wr_data  = d;
        for (int k = 0; k < 64 && !a; k++) cyc(a, we);
        wr_valid = 1'b0;
        chk("wr_accept", 32'(a), 32'(1));
    endtask

    task automatic drain(input int limit);
        logic a, we;
        rd_ready = 1'b1;
        for (int k = 0; k < limit && level != 10'd0; k++) cyc(a, we);
        rd_ready = 1'b0;
        chk("drain_level", 32'(level), 32'(0));
        chk("drain_queue_empty", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        logic a, we, prev_we;
        int   p0, nw, nacc;

        rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
`ifdef BRAM_FIFO_HWM_EN
        hwm_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_ready", 32'(wr_ready), 32'(0));
        chk("rst_rd_valid", 32'(rd_valid), 32'(0));
        chk("rst_rd_data",  32'(rd_data),  32'(0));
        chk("rst_level",    32'(level),    32'(0));
        chk("rst_ram_we",   32'(ram_we),   32'(0));
        chk("rst_ram_addr", 32'(ram_addr), 32'(0));
        chk("rst_ram_din",  32'(ram_din),  32'(0));
        rst = 1'b0;

        // 1: three words, first-word latency, ordered pop
        write_word(8'hAA);
        chk("t1_rdv_after_wr", 32'(rd_valid), 32'(0));
        idle(1);
        chk("t1_rdv_plus1", 32'(rd_valid), 32'(0));
        idle(1);
        chk("t1_rdv_plus2", 32'(rd_valid), 32'(1));
        chk("t1_head_aa", 32'(rd_data), 32'hAA);
        write_word(8'h55);
        write_word(8'hFF);
        idle(4);
        chk("t1_level3", 32'(level), 32'(3));
        chk("t1_head_hold", 32'(rd_data), 32'hAA);
        p0 = n_pop;
        drain(20);
        chk("t1_pops", 32'(n_pop - p0), 32'(3));

        // 2: fill to DEPTH+2, held word survives full, drain in order
        for (int i = 0; i < 258; i++) write_word(8'(i));
        chk("t2_level258", 32'(level), 32'(258));
        wr_valid = 1'b1; wr_data = 8'hA5;
        idle(2);
        chk("t2_full_wr_ready", 32'(wr_ready), 32'(0));
        chk("t2_full_level", 32'(level), 32'(258));
        p0 = n_pop;
        rd_ready = 1'b1;
        a = 1'b0;
        for (int k = 0; k < 16 && !a; k++) cyc(a, we);
        chk("t2_held_accepted", 32'(a), 32'(1));
        wr_valid = 1'b0;
        drain(800);
        chk("t2_pops", 32'(n_pop - p0), 32'(259));

        // 3: full contention on a pre-loaded FIFO
        for (int i = 0; i < 4; i++) write_word(8'hB0 + 8'(i));
        idle(3);
        wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 8'hC0;
        nacc = 0; prev_we = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cyc(a, we);
            if (k > 0) chk("t3_alternate", 32'(we), 32'(!prev_we));
            prev_we = we;
            if (a) begin
                nacc++;
                wr_data = wr_data + 8'd1;
            end
        end
        chk("t3_writes", 32'(nacc), 32'(20));
        wr_valid = 1'b0;
        drain(100);

        // 4: 300 words streamed through at a steady level, crossing pointer and data wrap
        for (int i = 0; i < 10; i++) write_word(8'(i));
        p0 = n_pop;
        wr_valid = 1'b1; rd_ready = 1'b1; nw = 10; wr_data = 8'(nw);
        for (int k = 0; k < 1500 && nw < 300; k++) begin
            cyc(a, we);
            if (a) begin
                nw++;
                wr_data = 8'(nw);
            end
        end
        wr_valid = 1'b0;
        chk("t4_written", 32'(nw), 32'(300));
        drain(100);
        chk("t4_pops", 32'(n_pop - p0), 32'(300));

        // 5: reset with a read in flight and words buffered
        for (int i = 0; i < 4; i++) write_word(8'h01 + 8'(i));
        idle(3);
        rd_ready = 1'b1;
        cyc(a, we);
        rd_ready = 1'b0;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_q.delete();
        chk("t5_rd_valid", 32'(rd_valid), 32'(0));
        chk("t5_level", 32'(level), 32'(0));
        #1;
        chk("t5_ram_we", 32'(ram_we), 32'(0));
        @(posedge clk);
        #1;
        write_word(8'h3C);
        idle(2);
        chk("t5_rd_valid_3c", 32'(rd_valid), 32'(1));
        chk("t5_rd_data_3c", 32'(rd_data), 32'h3C);
        drain(20);

`ifdef BRAM_FIFO_HWM_EN
        // 6: high-water mark and its clear
        for (int i = 0; i < 5; i++) write_word(8'h60 + 8'(i));
        idle(2);
        drain(40);
        write_word(8'h70);
        write_word(8'h71);
        idle(3);
        chk("t6_hwm5", 32'(hwm), 32'(5));
        hwm_clr = 1'b1;
        idle(1);
        hwm_clr = 1'b0;
        chk("t6_hwm_clr", 32'(hwm), 32'(2));
        drain(20);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
